// File: rtl/alu_exec_ctrl.sv
// Execution-stage controller in front of an n-bit combinational ALU.
// Takes one operation per valid/ready handshake, drives the ALU inputs,
// and runs multi-bit shifts as repeated shift-by-1 passes.
// The result and C/Z/error flags are registered and held until the consumer takes them.
module alu_exec_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [3:0]   in_ctrl,
   input  logic         in_flag,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic         alu_flag_in,
   output logic [3:0]   alu_control,
   input  logic [N-1:0] alu_result,
   input  logic         alu_c,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         out_c,
   output logic         out_z,
   output logic         out_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [3:0]     ctrl_q, ctrl_d;
   logic           flag_q, flag_d;
   logic [N-1:0]   work_q, work_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]   res_q, res_d;
   logic           c_q, c_d;
   logic           z_q, z_d;
   logic           err_q, err_d;

   logic accept;
   logic in_is_shift;
   logic op_is_shift;
   logic op_illegal;

   assign in_ready    = rst_n && (state_q == ST_IDLE);
   assign accept      = in_valid && in_ready;
   assign in_is_shift = (in_ctrl == 4'd8) || (in_ctrl == 4'd9);
   assign op_is_shift = (ctrl_q == 4'd8) || (ctrl_q == 4'd9);
   assign op_illegal  = (ctrl_q > 4'd9);

   assign out_valid  = (state_q == ST_DONE);
   assign out_result = res_q;
   assign out_c      = c_q;
   assign out_z      = z_q;
   assign out_err    = err_q;

   // ALU input drive: only active in EXEC; shifts feed the running work value with B=1
   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_flag_in = 1'b0;
      alu_control = 4'd0;
      if (state_q == ST_EXEC) begin
         if (ctrl_q <= 4'd7) begin
            alu_a       = a_q;
            alu_b       = b_q;
            alu_flag_in = flag_q;
            alu_control = ctrl_q;
         end else if (op_is_shift && (cnt_q != '0)) begin
            alu_a       = work_q;
            alu_b       = N'(1);
            alu_flag_in = flag_q;
            alu_control = ctrl_q;
         end
      end
   end

   // Next-state logic for the FSM, operand capture, shift iteration and result registers
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      flag_d  = flag_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      c_d     = c_q;
      z_d     = z_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = in_a;
               b_d     = in_b;
               ctrl_d  = in_ctrl;
               flag_d  = in_flag;
               work_d  = in_a;
               cnt_d   = in_is_shift ? CNT_W'(in_b) : CNT_W'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (op_illegal) begin
               res_d   = '0;
               c_d     = 1'b0;
               z_d     = 1'b1;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (op_is_shift) begin
               err_d = 1'b0;
               if (cnt_q == '0) begin
                  // Shift by zero: pass the operand through untouched
                  res_d   = work_q;
                  c_d     = 1'b0;
                  z_d     = (work_q == '0);
                  state_d = ST_DONE;
               end else begin
                  work_d = alu_result;
                  c_d    = alu_c;
                  cnt_d  = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     res_d   = alu_result;
                     z_d     = (alu_result == '0);
                     state_d = ST_DONE;
                  end
               end
            end else begin
               res_d   = alu_result;
               c_d     = ((ctrl_q == 4'd2) || (ctrl_q == 4'd6)) ? alu_c : 1'b0;
               z_d     = (alu_result == '0);
               err_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= 4'd0;
         flag_q  <= 1'b0;
         work_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         flag_q  <= flag_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         c_q     <= c_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end

endmodule
